pmod_input_reader: RTL and testbench
====================================

// Module: pmod_input_reader
// PURPOSE
//  Input-side counterpart of the LED/PMOD output driver: reads WIDTH external
//  PMOD pins (buttons/switches/jumpers) on the iCEstick. It synchronises each pin
//  into CLK, debounces it with a per-channel stability counter, and presents:
//   - clean levels;
//   - one-cycle rise/fall pulses;
//   - a wrapping event counter.
//  Consumers (LED/PMOD output logic, control FSMs) use these outputs directly.
// PARAMETERS
//  WIDTH          8   number of input channels
//  SYNC_STAGES    2   synchroniser flops per channel (>=2)
//  DEBOUNCE_BITS  16  stability window = 2**DEBOUNCE_BITS cycles (~5.5 ms @ 12 MHz)
//  CNT_BITS       8   width of EVENT_COUNT
// PORTS
//  CLK          in   1              system clock (12 MHz on iCEstick)
//  RST          in   1              asynchronous reset, active-high
//  PMOD_IN      in   WIDTH          raw asynchronous pin levels
//  STATE        out  WIDTH          debounced level per channel
//  RISE         out  WIDTH          1-cycle pulse: STATE bit went 0->1
//  FALL         out  WIDTH          1-cycle pulse: STATE bit went 1->0
//  CHANGED      out  1              |(RISE|FALL), same cycle as the pulses
//  EVENT_COUNT  out  CNT_BITS       number of cycles with any RISE bit set, wraps
// BEHAVIOUR
//  Reset (async assert, sync release to CLK):
//   - Synchroniser flops, STATE, RISE, FALL, CHANGED, EVENT_COUNT and all debounce
//     counters go to 0.
//   - Channel FSMs go to IDLE.
//   - Asserting RST mid-debounce discards the pending change.
//   - A pin held high through reset release produces a RISE once its window elapses.
//  Synchroniser: PMOD_IN[i] passes through SYNC_STAGES flops -> sync[i].
//  Channel FSM (independent per channel i, counter cnt[i] of DEBOUNCE_BITS bits):
//   - IDLE: cnt = 0.
//     - If sync[i] != STATE[i]: go to PENDING and set cnt = 1.
//   - PENDING:
//     - If sync[i] == STATE[i] (glitch): cnt = 0, go to IDLE, no pulse.
//     - Else if cnt == 2**DEBOUNCE_BITS-1: STATE[i] <= sync[i], pulse RISE[i] or
//       FALL[i] on the next cycle, cnt = 0, go to IDLE.
//     - Else cnt <= cnt + 1.
//   - cnt never wraps; the compare happens at the max value.
//  Latency:
//   - STATE[i] updates exactly 2**DEBOUNCE_BITS edges after sync[i] first differs.
//   - End to end: SYNC_STAGES + 2**DEBOUNCE_BITS edges from a clean pin step
//     (+1 sampling uncertainty).
//  RISE/FALL are registered, asserted for exactly 1 cycle, and coincide with the
//  first cycle STATE shows the new value. RISE[i] and FALL[i] are never both 1.
//  CHANGED is registered, equal to |(RISE|FALL) in the same cycle.
//  EVENT_COUNT:
//   - Increments by 1 in the cycle after any RISE bit is 1.
//   - Simultaneous rises on several channels count once.
//   - Wraps 2**CNT_BITS-1 -> 0 with no flag.
//   - FALL does not count.
//  Simultaneous channel events are fully independent; no arbitration or loss.
//  A pin toggling faster than the window never changes STATE (held stable).
// TESTING (bench uses DEBOUNCE_BITS=4, SYNC_STAGES=2 -> window 16 cycles)
//  1 Reset, PMOD_IN=0x00 -> all outputs 0. Step bit0 to 1 -> STATE=0x01 and
//    RISE=0x01 for one cycle, 18(+1) edges after the step. EVENT_COUNT=1.
//  2 Glitch: bit1 high for 10 cycles, then low -> STATE, RISE, FALL stay 0 and
//    EVENT_COUNT is unchanged. A 15-cycle pulse is also rejected; a 17-cycle
//    pulse is accepted.
//  3 Bits 2 and 5 rise together -> RISE=0x24 in one cycle and EVENT_COUNT
//    increments by exactly 1. Then drop bit2 -> FALL=0x04 and CHANGED=1 for
//    one cycle only.
//  4 Wrap: 256 debounced rise/fall pairs on bit0 -> EVENT_COUNT goes 255 -> 0.
//  5 Reset mid-op: bit3 pending at cnt=10, pulse RST async (not CLK-aligned)
//    -> all outputs 0 immediately. Hold PMOD_IN=0x08 -> RISE=0x08 a full
//    window after release.
//  6 Random per-pin bouncing bursts (<16 cycles) ending in a stable level ->
//    scoreboard checks STATE equals the final level, with exactly one RISE or
//    FALL per accepted change.

Source files
------------

// File: rtl/pmod_input_reader_if.sv
// Signal bundle between the PMOD pins, the input reader and its consumers.
// The reader drives the debounced outputs; the pin side drives pmod_in.
interface pmod_input_reader_if #(
  parameter int WIDTH    = 8,
  parameter int CNT_BITS = 8
);
  logic [WIDTH-1:0]    pmod_in;
  logic [WIDTH-1:0]    state;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;
  logic                changed;
  logic [CNT_BITS-1:0] event_count;

  modport master (
    output pmod_in,
    input  state, rise, fall, changed, event_count
  );

  modport slave (
    input  pmod_in,
    output state, rise, fall, changed, event_count
  );
endinterface

// File: rtl/pmod_input_reader.sv
// Synchronises and debounces WIDTH PMOD pins.
// Provides clean levels, one-cycle rise/fall pulses and a wrapping rise-event counter.
module pmod_input_reader #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 16,
  parameter int CNT_BITS      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pmod_input_reader_if.slave    bus
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } chan_state_t;

  localparam logic [DEBOUNCE_BITS-1:0] CNT_ZERO = {DEBOUNCE_BITS{1'b0}};
  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE  = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX  = {DEBOUNCE_BITS{1'b1}};

  logic [WIDTH-1:0]         r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]         w_sync;
  chan_state_t              r_fsm [WIDTH];
  chan_state_t              w_fsm_nxt [WIDTH];
  logic [DEBOUNCE_BITS-1:0] r_cnt [WIDTH];
  logic [DEBOUNCE_BITS-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0]         w_accept;
  logic [WIDTH-1:0]         w_state_nxt;
  logic [WIDTH-1:0]         r_state;
  logic [WIDTH-1:0]         r_rise;
  logic [WIDTH-1:0]         r_fall;
  logic                     r_changed;
  logic [CNT_BITS-1:0]      r_event_count;

  // Metastability chain from the raw pins into the clock domain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= {WIDTH{1'b0}};
      end
    end else begin
      r_sync[0] <= bus.pmod_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Per-channel debounce FSM: a change is accepted after a full window of mismatch
  always_comb begin
    w_accept = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_fsm_nxt[i] = r_fsm[i];
      w_cnt_nxt[i] = r_cnt[i];
      case (r_fsm[i])
        ST_IDLE: begin
          if (w_sync[i] != r_state[i]) begin
            w_fsm_nxt[i] = ST_PENDING;
            w_cnt_nxt[i] = CNT_ONE;
          end else begin
            w_fsm_nxt[i] = ST_IDLE;
            w_cnt_nxt[i] = CNT_ZERO;
          end
        end
        ST_PENDING: begin
          if (w_sync[i] == r_state[i]) begin
            w_fsm_nxt[i] = ST_IDLE;
            w_cnt_nxt[i] = CNT_ZERO;
          end else if (r_cnt[i] == CNT_MAX) begin
            w_accept[i]  = 1'b1;
            w_fsm_nxt[i] = ST_IDLE;
            w_cnt_nxt[i] = CNT_ZERO;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        default: begin
          w_fsm_nxt[i] = ST_IDLE;
          w_cnt_nxt[i] = CNT_ZERO;
        end
      endcase
    end
    w_state_nxt = (r_state & ~w_accept) | (w_sync & w_accept);
  end

  // FSM state and counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_fsm[i] <= ST_IDLE;
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_fsm[i] <= w_fsm_nxt[i];
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Clean level, edge pulses aligned with the new level, and the rise counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= {WIDTH{1'b0}};
      r_rise        <= {WIDTH{1'b0}};
      r_fall        <= {WIDTH{1'b0}};
      r_changed     <= 1'b0;
      r_event_count <= {CNT_BITS{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_rise        <= w_accept & w_sync;
      r_fall        <= w_accept & ~w_sync;
      r_changed     <= |w_accept;
      r_event_count <= r_event_count + CNT_BITS'(|r_rise);
    end
  end

  assign bus.state       = r_state;
  assign bus.rise        = r_rise;
  assign bus.fall        = r_fall;
  assign bus.changed     = r_changed;
  assign bus.event_count = r_event_count;

endmodule

// File: tb/tb_pmod_input_reader.sv
// Randomised bench for pmod_input_reader against a run-length debounce reference model.
// Window is 16 cycles (DEBOUNCE_BITS=4) with two synchroniser stages.
module tb_pmod_input_reader;
  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int CB  = 8;
  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmod_input_reader_if #(.WIDTH(W), .CNT_BITS(CB)) bus ();

  pmod_input_reader #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_BITS(DB), .CNT_BITS(CB)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a pin level is adopted once the synchronised sample has disagreed
  // with the current level on WIN consecutive clock edges.
  logic [W-1:0]      m_h1, m_h2, m_level, m_rise, m_fall, m_ripe;
  logic              m_changed;
  logic [CB-1:0]     m_count;
  logic [W-1:0][7:0] m_run;

  function automatic logic [W-1:0] ripe_mask(logic [W-1:0] obs, logic [W-1:0] lvl,
                                             logic [W-1:0][7:0] run);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = (obs[i] != lvl[i]) && (run[i] == 8'(WIN - 1));
    return r;
  endfunction

  function automatic logic [W-1:0][7:0] next_run(logic [W-1:0] obs, logic [W-1:0] lvl,
                                                 logic [W-1:0][7:0] run);
    logic [W-1:0][7:0] n;
    for (int i = 0; i < W; i++) begin
      if (obs[i] != lvl[i] && run[i] != 8'(WIN - 1)) n[i] = run[i] + 8'd1;
      else n[i] = 8'd0;
    end
    return n;
  endfunction

  assign m_ripe = ripe_mask(m_h2, m_level, m_run);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h1 <= '0; m_h2 <= '0; m_level <= '0; m_rise <= '0; m_fall <= '0;
      m_changed <= 1'b0; m_count <= '0; m_run <= '0;
    end else begin
      m_h1      <= bus.pmod_in;
      m_h2      <= m_h1;
      m_run     <= next_run(m_h2, m_level, m_run);
      m_level   <= m_level ^ m_ripe;
      m_rise    <= m_ripe & m_h2;
      m_fall    <= m_ripe & ~m_h2;
      m_changed <= |m_ripe;
      m_count   <= m_count + 8'(|m_rise);
    end
  end

  int rise_cnt [W];
  int fall_cnt [W];
  int chg_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, compare every output with the model, tally pulses.
  task automatic tick();
    @(negedge clk);
    check("cyc_state",   32'(bus.state),       32'(m_level));
    check("cyc_rise",    32'(bus.rise),        32'(m_rise));
    check("cyc_fall",    32'(bus.fall),        32'(m_fall));
    check("cyc_changed", 32'(bus.changed),     32'(m_changed));
    check("cyc_count",   32'(bus.event_count), 32'(m_count));
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] += int'(bus.rise[i]);
      fall_cnt[i] += int'(bus.fall[i]);
    end
    chg_cycles += int'(bus.changed);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [W-1:0] snap_mask(input int base [W], input int now [W]);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = ((now[i] - base[i]) != 0);
    return m;
  endfunction

  function automatic int snap_total(input int base [W], input int now [W]);
    int t = 0;
    for (int i = 0; i < W; i++) t += now[i] - base[i];
    return t;
  endfunction

  initial begin
    int edges;
    int r0 [W];
    int f0 [W];
    int c0;
    logic [CB-1:0] cnt0;
    logic [W-1:0]  prev, mask, fin;

    for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
    rst = 1'b1;
    bus.pmod_in = 8'h00;
    run(3);

    // 1: reset state, then a clean step on bit0
    check("rst_state",   32'(bus.state),       32'h0);
    check("rst_rise",    32'(bus.rise),        32'h0);
    check("rst_fall",    32'(bus.fall),        32'h0);
    check("rst_changed", 32'(bus.changed),     32'h0);
    check("rst_count",   32'(bus.event_count), 32'h0);
    rst = 1'b0;
    run(3);
    bus.pmod_in = 8'h01;
    edges = 0;
    while (bus.state[0] == 1'b0 && edges < 40) begin tick(); edges++; end
    check("s1_latency", 32'(edges), 32'd18);
    check("s1_rise",    32'(bus.rise), 32'h01);
    tick();
    check("s1_rise_one_cycle", 32'(bus.rise), 32'h00);
    check("s1_count",          32'(bus.event_count), 32'd1);

    // 2: glitches of 10 and 15 cycles are rejected, 17 cycles is accepted
    for (int k = 0; k < 3; k++) begin
      int len;
      len = (k == 0) ? 10 : (k == 1) ? 15 : 17;
      r0 = rise_cnt; f0 = fall_cnt;
      bus.pmod_in = bus.pmod_in | 8'h02;
      run(len);
      bus.pmod_in = bus.pmod_in & ~8'h02;
      run(40);
      check("s2_state", 32'(bus.state), 32'h01);
      check("s2_rises", 32'(rise_cnt[1] - r0[1]), (k == 2) ? 32'd1 : 32'd0);
      check("s2_falls", 32'(fall_cnt[1] - f0[1]), (k == 2) ? 32'd1 : 32'd0);
      check("s2_count", 32'(bus.event_count), (k == 2) ? 32'd2 : 32'd1);
    end

    // 3: simultaneous rises count once; a single fall pulses CHANGED for one cycle
    cnt0 = bus.event_count;
    bus.pmod_in = bus.pmod_in | 8'h24;
    edges = 0;
    while (bus.rise == 8'h00 && edges < 40) begin tick(); edges++; end
    check("s3_rise", 32'(bus.rise), 32'h24);
    run(30);
    check("s3_count", 32'(bus.event_count), 32'(8'(cnt0 + 8'd1)));
    c0 = chg_cycles;
    bus.pmod_in = bus.pmod_in & ~8'h04;
    edges = 0;
    while (bus.fall == 8'h00 && edges < 40) begin tick(); edges++; end
    check("s3_fall",    32'(bus.fall),    32'h04);
    check("s3_changed", 32'(bus.changed), 32'h1);
    run(30);
    check("s3_changed_cycles", 32'(chg_cycles - c0), 32'd1);
    check("s3_count_fall", 32'(bus.event_count), 32'(8'(cnt0 + 8'd1)));

    // 4: event counter wraps 255 -> 0
    rst = 1'b1;
    bus.pmod_in = 8'h00;
    run(2);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      bus.pmod_in = 8'h01;
      run(20);
      bus.pmod_in = 8'h00;
      run(20);
      if (k == 254) check("s4_count_255", 32'(bus.event_count), 32'd255);
    end
    check("s4_count_wrap", 32'(bus.event_count), 32'd0);

    // 5: async reset while bit3 is mid-window
    bus.pmod_in = 8'h01;
    run(20);
    bus.pmod_in = 8'h09;
    run(12);
    #2 rst = 1'b1;
    bus.pmod_in = 8'h08;
    #1;
    check("s5_state",   32'(bus.state),       32'h0);
    check("s5_rise",    32'(bus.rise),        32'h0);
    check("s5_changed", 32'(bus.changed),     32'h0);
    check("s5_count",   32'(bus.event_count), 32'h0);
    tick();
    rst = 1'b0;
    edges = 0;
    while (bus.rise == 8'h00 && edges < 40) begin tick(); edges++; end
    check("s5_latency", 32'(edges), 32'd18);
    check("s5_rise_after_release", 32'(bus.rise), 32'h08);
    run(24);

    // 6: random bouncing bursts shorter than the window, then a stable level
    for (int r = 0; r < 40; r++) begin
      prev = bus.pmod_in;
      mask = 8'($urandom_range(1, 255));
      r0 = rise_cnt; f0 = fall_cnt;
      repeat ($urandom_range(1, 15)) begin
        bus.pmod_in = (bus.pmod_in & ~mask) | (8'($urandom) & mask);
        tick();
      end
      fin = (prev & ~mask) | (8'($urandom) & mask);
      bus.pmod_in = fin;
      run(24);
      check("s6_state",  32'(bus.state), 32'(fin));
      check("s6_rises",  32'(snap_mask(r0, rise_cnt)), 32'(fin & ~prev));
      check("s6_falls",  32'(snap_mask(f0, fall_cnt)), 32'(prev & ~fin));
      check("s6_pulses", 32'(snap_total(r0, rise_cnt) + snap_total(f0, fall_cnt)),
            32'($countones(fin ^ prev)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
